// File: rtl/iram_responder.sv
// iram_responder
// Responder side of the fetch-stage instruction-RAM interface. Accepts read
// and byte-strobed write requests over a req/ready handshake, stores them in
// an internal word array and returns read data with a single-cycle
// iram_rvalid pulse READ_LATENCY cycles after the read was accepted.
//
// Optional feature macro: IRAM_STALL_EN
//   When defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5) pulls
//   iram_ready low in pseudo-random cycles so the fetch stage's wait and
//   backup paths get exercised. iram_rvalid timing is not affected.
//
// XLEN is the core data width (32 in the core configuration).
module iram_responder #(
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 1,
   parameter int XLEN         = 32
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                iram_req,
   input  logic                iram_write,
   input  logic [XLEN/8-1:0]   iram_wstrb,
   input  logic [XLEN-1:0]     iram_addr,
   input  logic [XLEN-1:0]     iram_wdata,
   output logic                iram_ready,
   output logic                iram_rvalid,
   output logic [XLEN-1:0]     iram_rdata
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam int         NBYTES   = XLEN / 8;
   localparam logic [1:0] CNT_LOAD = 2'(READ_LATENCY - 1);

   // Only latencies of 1..4 fit the 2-bit countdown.
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_badLatency
      $error("iram_responder: READ_LATENCY must be in the range 1..4");
   end

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [1:0]            r_cnt;
   logic [1:0]            w_nextCnt;
   logic                  r_live;
   logic [XLEN-1:0]       r_rdata;
   logic [XLEN-1:0]       r_mem [DEPTH];

   logic                  w_stall;
   logic                  w_accept;
   logic                  w_rdAccept;
   logic                  w_wrAccept;
   logic [ADDR_WIDTH-1:0] w_wordIdx;
   logic                  w_unusedAddr;

   // Word index drops the byte offset; high address bits are ignored so
   // anything beyond the array wraps back into it.
   assign w_wordIdx    = iram_addr[ADDR_WIDTH+1:2];
   assign w_unusedAddr = ^{iram_addr[XLEN-1:ADDR_WIDTH+2], iram_addr[1:0]};

`ifdef IRAM_STALL_EN
   logic [7:0] r_lfsr;

   // Free-running stall generator; bit 0 decides whether this cycle stalls.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_lfsr <= 8'hA5;
      end else begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // Ready whenever no read is still counting down; the completing cycle
   // (cnt = 0) is ready too so reads can be accepted back-to-back.
   assign iram_ready  = r_live && !w_stall && ((r_state == IDLE) || (r_cnt == 2'd0));
   assign iram_rvalid = (r_state == PEND) && (r_cnt == 2'd0);
   assign iram_rdata  = r_rdata;

   assign w_accept   = iram_req && iram_ready;
   assign w_rdAccept = w_accept && !iram_write;
   assign w_wrAccept = w_accept && iram_write;

   // r_live keeps ready low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // State register and read-latency countdown.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   // A newly accepted read always restarts the countdown; otherwise a pending
   // read counts down and returns to IDLE once its rvalid cycle has passed.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      if (w_rdAccept) begin
         w_nextState = PEND;
         w_nextCnt   = CNT_LOAD;
      end else if (r_state == PEND) begin
         if (r_cnt != 2'd0) begin
            w_nextCnt = r_cnt - 2'd1;
         end else begin
            w_nextState = IDLE;
         end
      end
   end

   // Array write port with per-byte enables; contents are never reset.
   always_ff @(posedge clk) begin
      if (w_wrAccept) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (iram_wstrb[b]) begin
               r_mem[w_wordIdx][b*8 +: 8] <= iram_wdata[b*8 +: 8];
            end
         end
      end
   end

   // Read data is captured at acceptance and held until the next read.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_rdata <= '0;
      end else if (w_rdAccept) begin
         r_rdata <= r_mem[w_wordIdx];
      end
   end

endmodule

// File: tb/tb_iram_responder.sv
// tb_iram_responder
// Drives three iram_responder instances (READ_LATENCY 1, 2, 3) from one
// shared request stream. A behavioural model per instance tracks memory
// contents by word index and the cycle each accepted read is due, and the
// scenario tasks compare ready/rvalid/rdata against it or against fixed
// expected values.
module tb_iram_responder;

   localparam int AW   = 12;
   localparam int NDUT = 3;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [2:0]  rdyV;
   logic [2:0]  rvld;
   logic [31:0] rdat [NDUT];

   int nChecks = 0;
   int nPass   = 0;
   int lat [NDUT] = '{1, 2, 3};

   logic [31:0] mMem   [NDUT][4096];
   bit          mKnown [NDUT][4096];
   bit          pend   [NDUT];
   longint      due    [NDUT];
   logic [31:0] pData  [NDUT];
   bit          pKnown [NDUT];
   bit          live   [NDUT];
   longint      cyc = 0;

   iram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dutL1 (
      .clk(clk), .rst_b(rst_b), .iram_req(req), .iram_write(wr),
      .iram_wstrb(wstrb), .iram_addr(addr), .iram_wdata(wdata),
      .iram_ready(rdyV[0]), .iram_rvalid(rvld[0]), .iram_rdata(rdat[0]));

   iram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dutL2 (
      .clk(clk), .rst_b(rst_b), .iram_req(req), .iram_write(wr),
      .iram_wstrb(wstrb), .iram_addr(addr), .iram_wdata(wdata),
      .iram_ready(rdyV[1]), .iram_rvalid(rvld[1]), .iram_rdata(rdat[1]));

   iram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dutL3 (
      .clk(clk), .rst_b(rst_b), .iram_req(req), .iram_write(wr),
      .iram_wstrb(wstrb), .iram_addr(addr), .iram_wdata(wdata),
      .iram_ready(rdyV[2]), .iram_rvalid(rvld[2]), .iram_rdata(rdat[2]));

   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic r, input logic w, input logic [3:0] s,
                                input logic [31:0] a, input logic [31:0] dt);
      req   = r;
      wr    = w;
      wstrb = s;
      addr  = a;
      wdata = dt;
   endtask

   task automatic modelReset();
      for (int d = 0; d < NDUT; d++) begin
         pend[d] = 1'b0;
         live[d] = 1'b0;
      end
   endtask

   // Advance one clock; the model uses the ready seen before the edge to
   // decide what each instance accepted. Returns at the following negedge.
   task automatic tick();
      logic [2:0]  acc;
      logic [11:0] idx;
      acc = (rst_b && req) ? rdyV : 3'b000;
      idx = addr[13:2];
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) begin
         if (rst_b) begin
            if (pend[d] && cyc == due[d]) pend[d] = 1'b0;
            if (acc[d] && wr) begin
               for (int b = 0; b < 4; b++) begin
                  if (wstrb[b]) mMem[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
               end
               if (wstrb == 4'hF) mKnown[d][idx] = 1'b1;
            end else if (acc[d]) begin
               pend[d]   = 1'b1;
               due[d]    = cyc + longint'(lat[d]);
               pData[d]  = mMem[d][idx];
               pKnown[d] = mKnown[d][idx];
            end
            live[d] = 1'b1;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (n) tick();
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      modelReset();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      repeat (3) tick();
      for (int d = 0; d < NDUT; d++) begin
         nChecks++;
         if (rdyV[d] !== 1'b0) $display("[TB] FAIL reset_ready dut%0d: got %0b expected 0", d, rdyV[d]);
         else nPass++;
         nChecks++;
         if (rvld[d] !== 1'b0) $display("[TB] FAIL reset_rvalid dut%0d: got %0b expected 0", d, rvld[d]);
         else nPass++;
         nChecks++;
         if (rdat[d] !== 32'h0) $display("[TB] FAIL reset_rdata dut%0d: got %h expected 0", d, rdat[d]);
         else nPass++;
      end
      rst_b = 1'b1;
      tick();
`ifndef IRAM_STALL_EN
      for (int d = 0; d < NDUT; d++) begin
         nChecks++;
         if (rdyV[d] !== 1'b1) $display("[TB] FAIL ready_after_reset dut%0d: got %0b expected 1", d, rdyV[d]);
         else nPass++;
      end
`endif
   endtask

   task automatic test_write_read();
      idle(2);
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      tick();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         for (int d = 0; d < NDUT; d++) begin
            nChecks++;
            if (rvld[d] !== (k == lat[d])) $display("[TB] FAIL raw_rvalid dut%0d k%0d: got %0b expected %0b", d, k, rvld[d], (k == lat[d]));
            else nPass++;
            if (k == lat[d]) begin
               nChecks++;
               if (rdat[d] !== 32'hDEADBEEF) $display("[TB] FAIL raw_rdata dut%0d: got %h expected deadbeef", d, rdat[d]);
               else nPass++;
            end
         end
         tick();
      end
   endtask

   task automatic test_partial_strobe();
      idle(2);
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
      tick();
      applyStimulus(1'b1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
      tick();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         for (int d = 0; d < NDUT; d++) begin
            if (k == lat[d]) begin
               nChecks++;
               if (rvld[d] !== 1'b1 || rdat[d] !== 32'h11BB33DD)
                  $display("[TB] FAIL strobe_merge dut%0d: got rvalid=%0b rdata=%h expected rvalid=1 rdata=11bb33dd", d, rvld[d], rdat[d]);
               else nPass++;
            end
         end
         tick();
      end
   endtask

   task automatic test_latency3();
      logic [31:0] rdAddr  [4] = '{32'h10, 32'h10, 32'h10, 32'h20};
      bit          expRdy3 [8] = '{1, 0, 0, 1, 0, 0, 1, 1};
      bit          expRv3  [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
      bit          expRv1  [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
      idle(3);
      for (int k = 0; k < 8; k++) begin
         nChecks++;
         if (rdyV[2] !== expRdy3[k]) $display("[TB] FAIL lat3_ready k%0d: got %0b expected %0b", k, rdyV[2], expRdy3[k]);
         else nPass++;
         nChecks++;
         if (rvld[2] !== expRv3[k]) $display("[TB] FAIL lat3_rvalid k%0d: got %0b expected %0b", k, rvld[2], expRv3[k]);
         else nPass++;
         nChecks++;
         if (rvld[0] !== expRv1[k]) $display("[TB] FAIL lat1_rvalid k%0d: got %0b expected %0b", k, rvld[0], expRv1[k]);
         else nPass++;
         if (k == 3 || k == 6) begin
            nChecks++;
            if (rdat[2] !== ((k == 3) ? 32'hDEADBEEF : 32'h11BB33DD))
               $display("[TB] FAIL lat3_rdata k%0d: got %h expected %h", k, rdat[2], ((k == 3) ? 32'hDEADBEEF : 32'h11BB33DD));
            else nPass++;
         end
         if (k == 4) begin
            nChecks++;
            if (rdat[0] !== 32'h11BB33DD) $display("[TB] FAIL lat1_b2b_rdata: got %h expected 11bb33dd", rdat[0]);
            else nPass++;
         end
         if (k < 4) applyStimulus(1'b1, 1'b0, 4'h0, rdAddr[k], 32'h0);
         else       applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         tick();
      end
   endtask

   task automatic test_alias();
      idle(2);
      applyStimulus(1'b1, 1'b1, 4'hF, 32'h4000_0008, 32'h5);
      tick();
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         for (int d = 0; d < NDUT; d++) begin
            if (k == lat[d]) begin
               nChecks++;
               if (rvld[d] !== 1'b1 || rdat[d] !== 32'h5)
                  $display("[TB] FAIL alias dut%0d: got rvalid=%0b rdata=%h expected rvalid=1 rdata=00000005", d, rvld[d], rdat[d]);
               else nPass++;
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_read();
      idle(3);
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      tick();
      rst_b = 1'b0;
      modelReset();
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      for (int d = 0; d < NDUT; d++) begin
         nChecks++;
         if (rdat[d] !== 32'h0) $display("[TB] FAIL midrst_rdata dut%0d: got %h expected 0", d, rdat[d]);
         else nPass++;
      end
      tick();
      tick();
      rst_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         for (int d = 0; d < NDUT; d++) begin
            nChecks++;
            if (rvld[d] !== 1'b0 || rdat[d] !== 32'h0)
               $display("[TB] FAIL midrst_norvalid dut%0d k%0d: got rvalid=%0b rdata=%h expected rvalid=0 rdata=0", d, k, rvld[d], rdat[d]);
            else nPass++;
         end
         tick();
      end
   endtask

   task automatic test_random(input int nCycles);
      int          lowIdle;
      bit          eRv;
      bit          eRdy;
      logic [31:0] a;
      lowIdle = 0;
      idle(4);
      for (int w = 0; w < 16; w++) begin
         applyStimulus(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom);
         tick();
      end
      for (int c = 0; c < nCycles; c++) begin
         for (int d = 0; d < NDUT; d++) begin
            eRv  = pend[d] && (cyc == due[d]);
            eRdy = live[d] && !(pend[d] && (cyc < due[d]));
            nChecks++;
            if (rvld[d] !== eRv) $display("[TB] FAIL rand_rvalid dut%0d cyc%0d: got %0b expected %0b", d, cyc, rvld[d], eRv);
            else nPass++;
`ifdef IRAM_STALL_EN
            if (!eRdy) begin
               nChecks++;
               if (rdyV[d] !== 1'b0) $display("[TB] FAIL rand_ready_busy dut%0d cyc%0d: got %0b expected 0", d, cyc, rdyV[d]);
               else nPass++;
            end else if (!pend[d] && rdyV[d] === 1'b0) begin
               lowIdle++;
            end
`else
            nChecks++;
            if (rdyV[d] !== eRdy) $display("[TB] FAIL rand_ready dut%0d cyc%0d: got %0b expected %0b", d, cyc, rdyV[d], eRdy);
            else nPass++;
`endif
            if (eRv && pKnown[d]) begin
               nChecks++;
               if (rdat[d] !== pData[d]) $display("[TB] FAIL rand_rdata dut%0d cyc%0d: got %h expected %h", d, cyc, rdat[d], pData[d]);
               else nPass++;
            end
         end
         a      = $urandom;
         a[13:6] = 8'h00;
         a[5:2]  = 4'($urandom_range(0, 15));
         applyStimulus($urandom_range(0, 99) < 75, $urandom_range(0, 2) == 0,
                       4'($urandom), a, $urandom);
         tick();
      end
`ifdef IRAM_STALL_EN
      nChecks++;
      if (lowIdle <= 0) $display("[TB] FAIL stall_seen: got %0d idle low-ready cycles expected at least 1", lowIdle);
      else nPass++;
`endif
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         pend[d]   = 1'b0;
         due[d]    = 0;
         pData[d]  = 32'h0;
         pKnown[d] = 1'b0;
         live[d]   = 1'b0;
      end
      rst_b = 1'b0;
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      test_reset();
`ifndef IRAM_STALL_EN
      test_write_read();
      test_partial_strobe();
      test_latency3();
      test_alias();
      test_reset_mid_read();
      test_random(600);
`else
      test_random(1000);
`endif
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
